// File: rtl/eater_pkg.sv
// eater_pkg: opcodes, control-word bit indices and microstep count for the control sequencer
package eater_pkg;
  localparam int NSTEPS_DEF = 5;
  localparam int HLT = 15, MI = 14, RI = 13, RO = 12, IO = 11, II = 10, AI = 9, AO = 8;
  localparam int EO = 7, SU = 6, BI = 5, OI = 4, CE = 3, CO = 2, J = 1, FI = 0;
  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_STA = 4'h4,
    OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC = 4'h7, OP_JZ = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF
  } opcode_t;
  function automatic logic [15:0] cb(input int i);
    return 16'(1) << i;
  endfunction
endpackage

// File: rtl/microcode_rom.sv
// microcode_rom: pure combinational decode of (step, opcode, flags) to the control word
module microcode_rom
  import eater_pkg::*;
(
  input  logic [2:0]  step,
  input  logic [3:0]  ir_op,
  input  logic        cf,
  input  logic        zf,
  output logic [15:0] ctrl
);
  always_comb begin
    ctrl = '0;
    case (step)
      3'd0: ctrl = cb(CO) | cb(MI);
      3'd1: ctrl = cb(RO) | cb(II) | cb(CE);
      3'd2:
        case (ir_op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl = cb(IO) | cb(MI);
          OP_LDI: ctrl = cb(IO) | cb(AI);
          OP_JMP: ctrl = cb(IO) | cb(J);
          OP_JC:  ctrl = cf ? cb(IO) | cb(J) : '0;
          OP_JZ:  ctrl = zf ? cb(IO) | cb(J) : '0;
          OP_OUT: ctrl = cb(AO) | cb(OI);
          OP_HLT: ctrl = cb(HLT);
          default: ctrl = '0;
        endcase
      3'd3:
        case (ir_op)
          OP_LDA: ctrl = cb(RO) | cb(AI);
          OP_ADD, OP_SUB: ctrl = cb(RO) | cb(BI);
          OP_STA: ctrl = cb(AO) | cb(RI);
          default: ctrl = '0;
        endcase
      3'd4:
        case (ir_op)
          OP_ADD: ctrl = cb(EO) | cb(AI) | cb(FI);
          OP_SUB: ctrl = cb(EO) | cb(AI) | cb(FI) | cb(SU);
          default: ctrl = '0;
        endcase
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/control_seq.sv
// control_seq: microstep counter with run gating and halt latch around microcode_rom.
// Define EARLY_END_EN to restart fetch right after an instruction's last non-zero microstep.
module control_seq
  import eater_pkg::*;
#(
  parameter int NSTEPS = NSTEPS_DEF
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        run,
  input  logic [3:0]  ir_op,
  input  logic        cf,
  input  logic        zf,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        halted
);
  logic [15:0] word;
  logic [2:0]  step_nxt;
  logic        halted_nxt, last, adv;
  microcode_rom u_rom (.step(step), .ir_op(ir_op), .cf(cf), .zf(zf), .ctrl(word));
`ifdef EARLY_END_EN
  logic [15:0]       words [NSTEPS];
  logic [NSTEPS-1:0] live;
  // Look-ahead copies of the ROM tell whether any later step still does work
  for (genvar i = 0; i < NSTEPS; i++) begin : g_look
    microcode_rom u_look (.step(3'(i)), .ir_op(ir_op), .cf(cf), .zf(zf), .ctrl(words[i]));
    assign live[i] = |words[i];
  end
  assign last = (step == 3'(NSTEPS - 1)) || (((live >> step) >> 1) == '0);
`else
  assign last = step == 3'(NSTEPS - 1);
`endif
  assign adv = run && !halted;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      step   <= '0;
      halted <= 1'b0;
    end else begin
      step   <= step_nxt;
      halted <= halted_nxt;
    end
  always_comb begin
    halted_nxt = halted | (adv & word[HLT]);
    step_nxt   = (!adv || word[HLT]) ? step : last ? '0 : step + 3'd1;
  end
  always_comb ctrl = !clr_n ? '0 : halted ? cb(HLT) : run ? word : '0;
endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: scoreboard bench; each queued entry is the run level for one cycle plus the expected outputs
module tb_control_seq;
`ifdef EARLY_END_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic        clk = 1'b0, clr_n, run, cf, zf;
  logic [3:0]  ir_op;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        halted;
  int tests = 0, fails = 0;

  typedef struct {
    logic        run;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;
  } exp_t;
  exp_t sb[$];

  control_seq dut (.clk(clk), .clr_n(clr_n), .run(run), .ir_op(ir_op), .cf(cf), .zf(zf),
                   .ctrl(ctrl), .step(step), .halted(halted));

  always #5 clk = ~clk;

  function automatic void want(logic r, logic [15:0] c, logic [2:0] s, logic h);
    sb.push_back('{r, c, s, h});
  endfunction

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    #1;
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    int n = 0;
    ir_op = 4'h2; cf = 0; zf = 0; run = 1;
    do_reset();
    repeat (3) @(negedge clk);
    #1;
    clr_n = 1'b0;
    #1;
    tests++;
    if ({ctrl, step, halted} !== {16'h0, 3'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_async: ctrl=%h step=%0d halted=%b, want ctrl=0000 step=0 halted=0", ctrl, step, halted);
    end
    clr_n = 1'b1;
    want(1, 16'h4004, 0, 0); want(1, 16'h1408, 1, 0); want(1, 16'h4800, 2, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); run = e.run; #1;
      tests++;
      if ({ctrl, step, halted} !== {e.ctrl, e.step, e.halted}) begin
        fails++;
        $display("FAIL reset[%0d]: ctrl=%h step=%0d halted=%b, want ctrl=%h step=%0d halted=%b",
                 n, ctrl, step, halted, e.ctrl, e.step, e.halted);
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_opcode(input string name, input logic [3:0] op, input logic c, input logic z);
    exp_t e;
    int n = 0;
    ir_op = op; cf = c; zf = z; run = 1;
    do_reset();
    while (sb.size() > 0) begin
      e = sb.pop_front(); run = e.run; #1;
      tests++;
      if ({ctrl, step, halted} !== {e.ctrl, e.step, e.halted}) begin
        fails++;
        $display("FAIL %s[%0d]: ctrl=%h step=%0d halted=%b, want ctrl=%h step=%0d halted=%b",
                 name, n, ctrl, step, halted, e.ctrl, e.step, e.halted);
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_jumps();
    for (int k = 0; k < 4; k++) begin
      logic [3:0] op = (k < 2) ? 4'h7 : 4'h8;
      logic f = k[0];
      want(1, 16'h4004, 0, 0); want(1, 16'h1408, 1, 0);
      if (f) want(1, 16'h0802, 2, 0);
      if (f && !EARLY) begin want(1, 16'h0, 3, 0); want(1, 16'h0, 4, 0); end
      if (!f && !EARLY) begin want(1, 16'h0, 2, 0); want(1, 16'h0, 3, 0); want(1, 16'h0, 4, 0); end
      want(1, 16'h4004, 0, 0);
      test_opcode(op == 4'h7 ? (f ? "jc_taken" : "jc_not") : (f ? "jz_taken" : "jz_not"),
                  op, op == 4'h7 ? f : !f, op == 4'h8 ? f : !f);
    end
  endtask

  task automatic test_halt();
    exp_t e;
    int n = 0;
    want(1, 16'h4004, 0, 0); want(1, 16'h1408, 1, 0); want(1, 16'h8000, 2, 0);
    for (int i = 0; i < 20; i++) want(i < 10, 16'h8000, 2, 1);
    test_opcode("halt", 4'hF, 0, 0);
    run = 1;
    clr_n = 1'b0;
    #1;
    tests++;
    if ({ctrl, step, halted} !== {16'h0, 3'd0, 1'b0}) begin
      fails++;
      $display("FAIL halt_clear: ctrl=%h step=%0d halted=%b, want ctrl=0000 step=0 halted=0", ctrl, step, halted);
    end
    clr_n = 1'b1;
    want(1, 16'h4004, 0, 0); want(1, 16'h1408, 1, 0); want(1, 16'h8000, 2, 0); want(1, 16'h8000, 2, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); run = e.run; #1;
      tests++;
      if ({ctrl, step, halted} !== {e.ctrl, e.step, e.halted}) begin
        fails++;
        $display("FAIL halt_restart[%0d]: ctrl=%h step=%0d halted=%b, want ctrl=%h step=%0d halted=%b",
                 n, ctrl, step, halted, e.ctrl, e.step, e.halted);
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_pause();
    want(1, 16'h4004, 0, 0); want(1, 16'h1408, 1, 0); want(1, 16'h4800, 2, 0);
    repeat (3) want(0, 16'h0, 3, 0);
    want(1, 16'h1200, 3, 0);
    if (!EARLY) want(1, 16'h0, 4, 0);
    want(1, 16'h4004, 0, 0);
    test_opcode("pause_lda", 4'h1, 0, 0);
  endtask

  task automatic test_halt_run();
    want(1, 16'h4004, 0, 0); want(1, 16'h1408, 1, 0);
    repeat (3) want(0, 16'h0, 2, 0);
    want(1, 16'h8000, 2, 0); want(0, 16'h8000, 2, 1); want(1, 16'h8000, 2, 1);
    test_opcode("halt_paused", 4'hF, 0, 0);
  endtask

  initial begin
    clr_n = 0; run = 0; ir_op = 0; cf = 0; zf = 0;
    test_reset();
    want(1, 16'h4004, 0, 0); want(1, 16'h1408, 1, 0); want(1, 16'h4800, 2, 0);
    want(1, 16'h1020, 3, 0); want(1, 16'h0281, 4, 0); want(1, 16'h4004, 0, 0);
    test_opcode("add", 4'h2, 0, 0);
    want(1, 16'h4004, 0, 0); want(1, 16'h1408, 1, 0); want(1, 16'h4800, 2, 0);
    want(1, 16'h1020, 3, 0); want(1, 16'h02c1, 4, 0); want(1, 16'h4004, 0, 0);
    test_opcode("sub", 4'h3, 1, 1);
    want(1, 16'h4004, 0, 0); want(1, 16'h1408, 1, 0); want(1, 16'h0a00, 2, 0);
    if (!EARLY) begin want(1, 16'h0, 3, 0); want(1, 16'h0, 4, 0); end
    want(1, 16'h4004, 0, 0);
    test_opcode("ldi", 4'h5, 0, 0);
    want(1, 16'h4004, 0, 0); want(1, 16'h1408, 1, 0); want(1, 16'h4800, 2, 0); want(1, 16'h2100, 3, 0);
    if (!EARLY) want(1, 16'h0, 4, 0);
    want(1, 16'h4004, 0, 0);
    test_opcode("sta", 4'h4, 0, 0);
    want(1, 16'h4004, 0, 0); want(1, 16'h1408, 1, 0); want(1, 16'h0110, 2, 0);
    if (!EARLY) begin want(1, 16'h0, 3, 0); want(1, 16'h0, 4, 0); end
    want(1, 16'h4004, 0, 0);
    test_opcode("out", 4'hE, 0, 0);
    want(1, 16'h4004, 0, 0); want(1, 16'h1408, 1, 0);
    if (!EARLY) begin want(1, 16'h0, 2, 0); want(1, 16'h0, 3, 0); want(1, 16'h0, 4, 0); end
    want(1, 16'h4004, 0, 0);
    test_opcode("undef_a", 4'hA, 1, 1);
    test_jumps();
    test_halt();
    test_pause();
    test_halt_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
